prio_int_ctrl: RTL and testbench

Clocked, parametrised interrupt controller between N peripheral request lines and the CPU interrupt-entry logic.
- Latches device requests and acknowledges them to the device.
- Arbitrates by per-device programmable priority, with round-robin among equal priorities.
- Masks requests against the CPU's current priority.
- Offers one vector at a time over a pending/acknowledge handshake, and tracks in-service devices until end-of-interrupt (EOI).

---
 rtl/prio_int_ctrl_if.sv | 32 +++
 rtl/prio_int_ctrl.sv | 137 +++++++++++++
 tb/tb_prio_int_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prio_int_ctrl_if.sv
// Request/offer bundle between peripherals, CPU interrupt-entry logic and prio_int_ctrl.
// The slave modport is the controller's view; master is the CPU/device side.
interface prio_int_ctrl_if #(
  parameter int NUM_DEV = 8,
  parameter int PRI_W   = 3,
  parameter int VEC_W   = 8,
  parameter int IDX_W   = 3
);
  logic [NUM_DEV-1:0]       irq;
  logic [NUM_DEV-1:0]       irq_en;
  logic [NUM_DEV*PRI_W-1:0] dev_pri;
  logic [PRI_W-1:0]         cpu_pri;
  logic                     int_ack;
  logic                     eoi;
  logic [IDX_W-1:0]         eoi_idx;
  logic                     pi;
  logic [VEC_W-1:0]         vector;
  logic [PRI_W-1:0]         vec_pri;
  logic [IDX_W-1:0]         vec_idx;
  logic [NUM_DEV-1:0]       dev_ack;
  logic [NUM_DEV-1:0]       in_service;

  modport slave (
    input  irq, irq_en, dev_pri, cpu_pri, int_ack, eoi, eoi_idx,
    output pi, vector, vec_pri, vec_idx, dev_ack, in_service
  );

  modport master (
    output irq, irq_en, dev_pri, cpu_pri, int_ack, eoi, eoi_idx,
    input  pi, vector, vec_pri, vec_idx, dev_ack, in_service
  );
endinterface

// File: rtl/prio_int_ctrl.sv
// Priority interrupt controller: latches device requests, arbitrates by priority with
// round-robin tie-break, offers one vector at a time and tracks in-service devices.
module prio_int_ctrl #(
  parameter int NUM_DEV    = 8,
  parameter int PRI_W      = 3,
  parameter int VEC_W      = 8,
  parameter int VEC_BASE   = 'h02,
  parameter int VEC_STRIDE = 4,
  parameter int IDX_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  prio_int_ctrl_if.slave   bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OFFER = 1'b1;

  logic [0:0]         r_state;
  logic [NUM_DEV-1:0] r_pending;
  logic [NUM_DEV-1:0] r_in_service;
  logic [NUM_DEV-1:0] r_dev_ack;
  logic [VEC_W-1:0]   r_vector;
  logic [PRI_W-1:0]   r_vec_pri;
  logic [IDX_W-1:0]   r_vec_idx;
  logic [IDX_W-1:0]   r_rr_ptr;

  logic [NUM_DEV-1:0] w_elig;
  logic [NUM_DEV-1:0] w_cap;
  logic [NUM_DEV-1:0] w_ack_set;
  logic [NUM_DEV-1:0] w_eoi_clr;
  logic               w_win_vld;
  logic [PRI_W-1:0]   w_win_pri;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_ack;
  logic               w_offer_ok;
  logic               w_preempt;
  logic [IDX_W-1:0]   w_rr_next;

  function automatic logic [PRI_W-1:0] pri_of(input logic [NUM_DEV*PRI_W-1:0] p,
                                              input logic [IDX_W-1:0] idx);
    return p[int'(idx)*PRI_W +: PRI_W];
  endfunction

  function automatic logic [VEC_W-1:0] vec_of(input logic [IDX_W-1:0] idx);
    return VEC_W'(VEC_BASE + VEC_STRIDE * int'(idx));
  endfunction

  always_comb begin
    w_cap     = bus.irq & bus.irq_en & ~r_pending & ~r_in_service;
    w_ack     = (r_state == S_OFFER) && bus.int_ack;
    w_elig    = '0;
    w_ack_set = '0;
    w_eoi_clr = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      w_elig[i]    = r_pending[i] & ~r_in_service[i] & bus.irq_en[i] &
                     (pri_of(bus.dev_pri, IDX_W'(i)) > bus.cpu_pri);
      w_ack_set[i] = w_ack && (r_vec_idx == IDX_W'(i));
      // Out-of-range eoi_idx never matches any device, so it is dropped here.
      w_eoi_clr[i] = bus.eoi && (bus.eoi_idx == IDX_W'(i));
    end
  end

  // Scan from rr_ptr upward; strict '>' keeps the first-found device on ties.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    w_win_vld = 1'b0;
    w_win_pri = '0;
    w_win_idx = '0;
    j         = 0;
    jj        = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_DEV) j = j - NUM_DEV;
      jj = IDX_W'(j);
      if (w_elig[jj] && (!w_win_vld || pri_of(bus.dev_pri, jj) > w_win_pri)) begin
        w_win_vld = 1'b1;
        w_win_pri = pri_of(bus.dev_pri, jj);
        w_win_idx = jj;
      end
    end
  end

  assign w_offer_ok = w_elig[r_vec_idx];
  assign w_preempt  = w_win_vld && (w_win_pri > r_vec_pri);
  assign w_rr_next  = (r_vec_idx == IDX_W'(NUM_DEV - 1)) ? '0 : r_vec_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pending    <= '0;
      r_in_service <= '0;
      r_dev_ack    <= '0;
      r_vector     <= '0;
      r_vec_pri    <= '0;
      r_vec_idx    <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_dev_ack    <= w_cap;
      r_pending    <= (r_pending | w_cap) & ~w_ack_set;
      // Ack's set is ORed last so it wins over a same-cycle EOI.
      r_in_service <= (r_in_service & ~w_eoi_clr) | w_ack_set;
      case (r_state)
        S_IDLE: begin
          if (w_win_vld) begin
            r_vector  <= vec_of(w_win_idx);
            r_vec_pri <= w_win_pri;
            r_vec_idx <= w_win_idx;
            r_state   <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (bus.int_ack) begin
            r_rr_ptr <= w_rr_next;
            r_state  <= S_IDLE;
          end else if (!w_offer_ok) begin
            r_state <= S_IDLE;
          end else if (w_preempt) begin
            r_vector  <= vec_of(w_win_idx);
            r_vec_pri <= w_win_pri;
            r_vec_idx <= w_win_idx;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pi         = (r_state == S_OFFER);
  assign bus.vector     = r_vector;
  assign bus.vec_pri    = r_vec_pri;
  assign bus.vec_idx    = r_vec_idx;
  assign bus.dev_ack    = r_dev_ack;
  assign bus.in_service = r_in_service;

endmodule

// File: tb/tb_prio_int_ctrl.sv
// Directed bench for prio_int_ctrl: expected offers are queued by the stimulus and
// popped by a monitor whenever a new vector is presented.
module tb_prio_int_ctrl;

  typedef struct packed {
    logic [7:0] vec;
    logic [2:0] pri;
    logic [2:0] idx;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t mon_e;
  logic prev_pi;
  logic [7:0] prev_vec;

  prio_int_ctrl_if #(.NUM_DEV(8), .PRI_W(3), .VEC_W(8), .IDX_W(3)) bus ();

  prio_int_ctrl #(
    .NUM_DEV(8), .PRI_W(3), .VEC_W(8), .VEC_BASE('h02), .VEC_STRIDE(4), .IDX_W(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

  // Scoreboard monitor: a rising pi or a changed vector under pi is one offer.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pi  <= 1'b0;
      prev_vec <= '0;
    end else begin
      if (bus.pi && (!prev_pi || bus.vector != prev_vec)) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL offer_unexpected got vec=%h pri=%0d idx=%0d want none",
                   bus.vector, bus.vec_pri, bus.vec_idx);
        end else begin
          mon_e = q.pop_front();
          if ({bus.vector, bus.vec_pri, bus.vec_idx} !== mon_e) begin
            bad++;
            $display("FAIL offer got vec=%h pri=%0d idx=%0d want vec=%h pri=%0d idx=%0d",
                     bus.vector, bus.vec_pri, bus.vec_idx, mon_e.vec, mon_e.pri, mon_e.idx);
          end
        end
      end
      prev_pi  <= bus.pi;
      prev_vec <= bus.vector;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic expect_offer(input logic [7:0] v, input logic [2:0] p, input logic [2:0] i);
    exp_t e;
    e.vec = v;
    e.pri = p;
    e.idx = i;
    q.push_back(e);
  endtask

  task automatic wait_pi();
    int n;
    n = 0;
    while (!bus.pi && n < 20) begin
      tick();
      n++;
    end
    if (!bus.pi) begin
      total++;
      bad++;
      $display("FAIL wait_pi got=timeout want=pi");
    end
  endtask

  task automatic ack_offer();
    wait_pi();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic do_eoi(input int idx);
    bus.eoi     = 1'b1;
    bus.eoi_idx = 3'(idx);
    tick();
    bus.eoi     = 1'b0;
  endtask

  task automatic set_all_pri(input int p);
    for (int i = 0; i < 8; i++) bus.dev_pri[i*3 +: 3] = 3'(p);
  endtask

  task automatic set_pri(input int i, input int p);
    bus.dev_pri[i*3 +: 3] = 3'(p);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.irq     = 8'hFF;
    bus.irq_en  = 8'hFF;
    bus.cpu_pri = 3'd0;
    bus.int_ack = 1'b0;
    bus.eoi     = 1'b0;
    bus.eoi_idx = 3'd0;
    set_all_pri(1);

    // Reset with all requests high, then capture all and serve in rotation.
    do_reset();
    rst_n = 1'b0;
    check("reset_pi", {31'd0, bus.pi}, 32'd0);
    check("reset_vec", {16'd0, bus.vector, 2'd0, bus.vec_pri, 3'd0, bus.vec_idx}, 32'd0);
    check("reset_ack_insvc", {16'd0, bus.dev_ack, bus.in_service}, 32'd0);
    for (int i = 0; i < 8; i++) expect_offer(8'(2 + 4 * i), 3'd1, 3'(i));
    rst_n = 1'b1;
    tick();
    check("capture_all_dev_ack", {24'd0, bus.dev_ack}, 32'h0000_00FF);
    check("capture_pi_latency", {31'd0, bus.pi}, 32'd0);
    bus.irq = 8'h00;
    tick();
    check("first_offer_pi", {31'd0, bus.pi}, 32'd1);
    check("dev_ack_one_cycle", {24'd0, bus.dev_ack}, 32'd0);
    for (int i = 0; i < 8; i++) ack_offer();
    check("all_in_service", {24'd0, bus.in_service}, 32'h0000_00FF);
    for (int i = 0; i < 8; i++) do_eoi(i);
    check("all_eoi", {24'd0, bus.in_service}, 32'd0);

    // Priority select.
    set_all_pri(0);
    set_pri(3, 5);
    set_pri(6, 2);
    bus.cpu_pri = 3'd1;
    expect_offer(8'h0E, 3'd5, 3'd3);
    expect_offer(8'h1A, 3'd2, 3'd6);
    bus.irq = 8'h48;
    tick();
    bus.irq = 8'h00;
    ack_offer();
    check("prio_insvc3", {24'd0, bus.in_service}, 32'h0000_0008);
    ack_offer();
    check("prio_insvc36", {24'd0, bus.in_service}, 32'h0000_0048);
    do_eoi(3);
    do_eoi(6);
    bus.cpu_pri = 3'd0;

    // Preemption by a strictly higher priority arrival.
    set_all_pri(0);
    set_pri(1, 2);
    set_pri(7, 6);
    expect_offer(8'h06, 3'd2, 3'd1);
    bus.irq = 8'h02;
    tick();
    bus.irq = 8'h00;
    wait_pi();
    expect_offer(8'h1E, 3'd6, 3'd7);
    expect_offer(8'h06, 3'd2, 3'd1);
    bus.irq = 8'h80;
    tick();
    check("preempt_pi_hold_a", {31'd0, bus.pi}, 32'd1);
    bus.irq = 8'h00;
    tick();
    check("preempt_pi_hold_b", {31'd0, bus.pi}, 32'd1);
    check("preempt_vector", {24'd0, bus.vector}, 32'h0000_001E);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    check("preempt_insvc7", {24'd0, bus.in_service}, 32'h0000_0080);
    ack_offer();
    check("preempt_insvc71", {24'd0, bus.in_service}, 32'h0000_0082);
    do_eoi(7);
    do_eoi(1);

    // Round-robin among equal priorities, with wrap of the pointer.
    do_reset();
    set_all_pri(0);
    set_pri(0, 4);
    set_pri(2, 4);
    set_pri(5, 4);
    expect_offer(8'h02, 3'd4, 3'd0);
    expect_offer(8'h0A, 3'd4, 3'd2);
    expect_offer(8'h16, 3'd4, 3'd5);
    bus.irq = 8'h25;
    tick();
    bus.irq = 8'h00;
    for (int i = 0; i < 3; i++) ack_offer();
    do_eoi(0);
    do_eoi(2);
    do_eoi(5);
    expect_offer(8'h02, 3'd4, 3'd0);
    expect_offer(8'h0A, 3'd4, 3'd2);
    bus.irq = 8'h05;
    tick();
    bus.irq = 8'h00;
    ack_offer();
    ack_offer();
    do_eoi(0);
    do_eoi(2);

    // Masking by CPU priority; pending survives and is re-offered.
    set_all_pri(0);
    set_pri(4, 3);
    expect_offer(8'h12, 3'd3, 3'd4);
    bus.irq = 8'h10;
    tick();
    bus.irq = 8'h00;
    wait_pi();
    bus.cpu_pri = 3'd3;
    tick();
    check("mask_pi_drop", {31'd0, bus.pi}, 32'd0);
    bus.cpu_pri = 3'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mask_all_pi", {31'd0, bus.pi}, 32'd0);
    end
    check("mask_no_insvc", {24'd0, bus.in_service}, 32'd0);
    expect_offer(8'h12, 3'd3, 3'd4);
    bus.cpu_pri = 3'd0;
    ack_offer();
    do_eoi(4);

    // EOI and re-capture of a still-high request.
    set_all_pri(0);
    set_pri(2, 1);
    expect_offer(8'h0A, 3'd1, 3'd2);
    expect_offer(8'h0A, 3'd1, 3'd2);
    bus.irq = 8'h04;
    tick();
    check("eoi_first_ack", {24'd0, bus.dev_ack}, 32'h0000_0004);
    ack_offer();
    check("eoi_insvc2", {24'd0, bus.in_service}, 32'h0000_0004);
    do_eoi(5);
    check("eoi_noop", {24'd0, bus.in_service}, 32'h0000_0004);
    check("held_irq_no_ack_a", {24'd0, bus.dev_ack}, 32'd0);
    tick();
    check("held_irq_no_ack_b", {24'd0, bus.dev_ack}, 32'd0);
    do_eoi(2);
    check("eoi_clear", {24'd0, bus.in_service}, 32'd0);
    check("eoi_no_ack_yet", {24'd0, bus.dev_ack}, 32'd0);
    tick();
    check("recapture_ack", {24'd0, bus.dev_ack}, 32'h0000_0004);
    bus.irq = 8'h00;
    wait_pi();
    bus.int_ack = 1'b1;
    bus.eoi     = 1'b1;
    bus.eoi_idx = 3'd2;
    tick();
    bus.int_ack = 1'b0;
    bus.eoi     = 1'b0;
    check("ack_beats_eoi", {24'd0, bus.in_service}, 32'h0000_0004);
    do_eoi(2);
    check("final_eoi", {24'd0, bus.in_service}, 32'd0);

    // Int_ack in IDLE is ignored.
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    tick();
    check("idle_ack_ignored", {23'd0, bus.pi, bus.in_service}, 32'd0);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
